// File: rtl/ap_ctrl_txn_tracker.sv
// Snoops one kernel's ap_ctrl_hs handshake, pairs starts with dones in order and
// streams one timestamped latency/interval record per transaction.
module ap_ctrl_txn_tracker #(
  parameter int TS_W       = 32,
  parameter int PEND_DEPTH = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            mon_start,
  input  logic            mon_ready,
  input  logic            mon_done,
  input  logic            mon_continue,
  input  logic            finish,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [15:0]     rec_seq,
  output logic [TS_W-1:0] rec_start_ts,
  output logic [TS_W-1:0] rec_done_ts,
  output logic [TS_W-1:0] rec_latency,
  output logic [TS_W-1:0] rec_interval,
  output logic [15:0]     drop_count,
  output logic [1:0]      err_flags,
  output logic            flush_done
);
  localparam int PW = $clog2(PEND_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PQ_MAX = (PW+1)'(PEND_DEPTH);
  localparam logic [FW:0] FQ_MAX = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FINISHING, S_FLUSHED} state_t;

  typedef struct packed {
    logic [15:0]     seq;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] done_ts;
    logic [TS_W-1:0] latency;
    logic [TS_W-1:0] interval;
  } rec_t;

  typedef struct packed {
    logic [15:0]     seq;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] interval;
  } pend_t;

  state_t          state, state_next;
  logic [TS_W-1:0] cnt, last_ts, acc_interval;
  logic            first_acc;
  logic [15:0]     seq;

  pend_t           pq_mem [PEND_DEPTH];
  logic [PW-1:0]   pq_rd, pq_wr;
  logic [PW:0]     pq_cnt;
  rec_t            fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]   f_rd, f_wr;
  logic [FW:0]     f_cnt;

  logic  finishing, gate, acc, dn, pq_empty, pq_full, acc_take;
  logic  pair_direct, pq_push, pq_pop, rec_push, f_push, f_pop, drop;
  pend_t oldest;
  rec_t  new_rec, head;

  // Accept is resolved before done, so a done on an empty queue can pair with
  // a start seen in the same cycle (combinational kernel, latency 0).
  always_comb begin
    finishing    = (state != S_IDLE);
    gate         = finish | finishing;
    acc          = mon_start & mon_ready & ~gate;
    dn           = mon_done & mon_continue & ~gate;
    pq_empty     = (pq_cnt == '0);
    pq_full      = (pq_cnt == PQ_MAX);
    acc_interval = first_acc ? '0 : cnt - last_ts;
    acc_take     = acc & (~pq_full | dn);
    pair_direct  = acc & dn & pq_empty;
    pq_push      = acc_take & ~pair_direct;
    pq_pop       = dn & ~pq_empty;
    rec_push     = pq_pop | pair_direct;
    f_pop        = (f_cnt != '0) & rec_ready;
    f_push       = rec_push & ((f_cnt != FQ_MAX) | f_pop);
    drop         = rec_push & ~f_push;
    oldest       = pq_mem[pq_rd];
    new_rec      = '0;
    if (pair_direct) begin
      new_rec.seq      = seq;
      new_rec.start_ts = cnt;
      new_rec.done_ts  = cnt;
      new_rec.latency  = '0;
      new_rec.interval = acc_interval;
    end else begin
      new_rec.seq      = oldest.seq;
      new_rec.start_ts = oldest.ts;
      new_rec.done_ts  = cnt;
      new_rec.latency  = cnt - oldest.ts;
      new_rec.interval = oldest.interval;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt        <= '0;
      last_ts    <= '0;
      first_acc  <= 1'b1;
      seq        <= '0;
      pq_rd      <= '0;
      pq_wr      <= '0;
      pq_cnt     <= '0;
      f_rd       <= '0;
      f_wr       <= '0;
      f_cnt      <= '0;
      drop_count <= '0;
      err_flags  <= '0;
    end else begin
      cnt <= cnt + TS_W'(1);
      // An overflowing accept still consumes a sequence number.
      if (acc) seq <= seq + 16'd1;
      if (acc_take) begin
        last_ts   <= cnt;
        first_acc <= 1'b0;
      end
      if (pq_push) pq_wr <= pq_wr + PW'(1);
      if (pq_pop)  pq_rd <= pq_rd + PW'(1);
      pq_cnt <= pq_cnt + (PW+1)'(pq_push) - (PW+1)'(pq_pop);
      if (f_push) f_wr <= f_wr + FW'(1);
      if (f_pop)  f_rd <= f_rd + FW'(1);
      f_cnt <= f_cnt + (FW+1)'(f_push) - (FW+1)'(f_pop);
      if (dn & pq_empty & ~acc) err_flags[0] <= 1'b1;
      if (acc & pq_full & ~dn)  err_flags[1] <= 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (pq_push) pq_mem[pq_wr] <= {seq, cnt, acc_interval};
    if (f_push)  fifo_mem[f_wr] <= new_rec;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (finish) state_next = S_FINISHING;
      S_FINISHING: if (f_cnt == '0) state_next = S_FLUSHED;
      S_FLUSHED:   state_next = S_FLUSHED;
      default:     state_next = S_IDLE;
    endcase
  end

  // Record fields read as zero whenever nothing is presented.
  always_comb begin
    head         = fifo_mem[f_rd];
    rec_valid    = (f_cnt != '0);
    rec_seq      = rec_valid ? head.seq      : '0;
    rec_start_ts = rec_valid ? head.start_ts : '0;
    rec_done_ts  = rec_valid ? head.done_ts  : '0;
    rec_latency  = rec_valid ? head.latency  : '0;
    rec_interval = rec_valid ? head.interval : '0;
    flush_done   = (state == S_FLUSHED) | ((state == S_FINISHING) & (f_cnt == '0));
  end
endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// Bench for ap_ctrl_txn_tracker: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a queue-based transaction model.
module tb_ap_ctrl_txn_tracker;
  localparam int TS_W       = 8;
  localparam int PEND_DEPTH = 4;
  localparam int FIFO_DEPTH = 8;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic            mon_start = 1'b0, mon_ready = 1'b0, mon_done = 1'b0;
  logic            mon_continue = 1'b1, finish = 1'b0, rec_ready = 1'b1;
  logic            rec_valid, flush_done;
  logic [15:0]     rec_seq, drop_count;
  logic [TS_W-1:0] rec_start_ts, rec_done_ts, rec_latency, rec_interval;
  logic [1:0]      err_flags;

  ap_ctrl_txn_tracker #(.TS_W(TS_W), .PEND_DEPTH(PEND_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .mon_start(mon_start), .mon_ready(mon_ready),
    .mon_done(mon_done), .mon_continue(mon_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_seq(rec_seq),
    .rec_start_ts(rec_start_ts), .rec_done_ts(rec_done_ts), .rec_latency(rec_latency),
    .rec_interval(rec_interval), .drop_count(drop_count), .err_flags(err_flags),
    .flush_done(flush_done)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [15:0]     seq;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] iv;
  } pend_t;

  typedef struct packed {
    logic [15:0]     seq;
    logic [TS_W-1:0] st;
    logic [TS_W-1:0] dn;
    logic [TS_W-1:0] lat;
    logic [TS_W-1:0] iv;
  } rec_t;

  pend_t           pq[$];
  rec_t            oq[$];
  logic [TS_W-1:0] m_cnt = '0, m_last = '0;
  logic [15:0]     m_seq = '0, m_drop = '0;
  logic [1:0]      m_err = '0;
  bit              m_first = 1'b1, m_fin = 1'b0, m_init = 1'b0;
  int              n_pass = 0, n_total = 0;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
  endtask

  // Transaction-level model: the accept is queued before the done pops, and a
  // record leaving this cycle frees its slot before the new one is placed.
  always @(posedge ap_clk) begin : model
    bit              gate, a, d, popping, have;
    pend_t           p;
    rec_t            r;
    logic [TS_W-1:0] iv;
    if (!ap_rst_n) begin
      pq.delete();
      oq.delete();
      m_cnt = '0; m_last = '0; m_seq = '0; m_drop = '0; m_err = '0;
      m_first = 1'b1; m_fin = 1'b0; m_init = 1'b1;
    end else begin
      gate    = finish || m_fin;
      a       = mon_start && mon_ready && !gate;
      d       = mon_done && mon_continue && !gate;
      popping = (oq.size() > 0) && rec_ready;
      have    = 1'b0;
      r       = '0;
      iv      = m_first ? '0 : TS_W'(m_cnt - m_last);
      if (a) begin
        if (pq.size() < PEND_DEPTH || d) begin
          pq.push_back('{m_seq, m_cnt, iv});
          m_last  = m_cnt;
          m_first = 1'b0;
        end else m_err[1] = 1'b1;
        m_seq = m_seq + 16'd1;
      end
      if (d) begin
        if (pq.size() > 0) begin
          p    = pq.pop_front();
          r    = '{p.seq, p.ts, m_cnt, TS_W'(m_cnt - p.ts), p.iv};
          have = 1'b1;
        end else m_err[0] = 1'b1;
      end
      if (popping) void'(oq.pop_front());
      if (have) begin
        if (oq.size() < FIFO_DEPTH) oq.push_back(r);
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (finish) m_fin = 1'b1;
      m_cnt = m_cnt + TS_W'(1);
    end
  end

  always @(negedge ap_clk) begin : compare
    rec_t e;
    bit   ev;
    if (m_init) begin
      ev = (oq.size() != 0);
      e  = '0;
      if (ev) e = oq[0];
      check_output("rec_valid", 64'(rec_valid), 64'(ev));
      check_output("rec_fields",
                   64'({rec_seq, rec_start_ts, rec_done_ts, rec_latency, rec_interval}), 64'(e));
      check_output("drop_count", 64'(drop_count), 64'(m_drop));
      check_output("err_flags", 64'(err_flags), 64'(m_err));
      check_output("flush_done", 64'(flush_done), 64'(m_fin && oq.size() == 0));
    end
  end

  task automatic wait_count(input int k);
    int n = 0;
    while (m_cnt != TS_W'(k) && n < 600) begin
      @(negedge ap_clk);
      n++;
    end
    if (m_cnt != TS_W'(k)) begin
      n_total++;
      $display("[TB] FAIL wait_count: got count %0d required %0d", m_cnt, k);
    end
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    {mon_start, mon_ready, mon_done, finish} = '0;
    mon_continue = 1'b1;
    rec_ready    = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic apply_stimulus(input int k, input bit accept, input bit done);
    wait_count(k);
    mon_start = accept;
    mon_ready = accept;
    mon_done  = done;
    @(negedge ap_clk);
    {mon_start, mon_ready, mon_done} = '0;
  endtask

  task automatic expect_rec(input string name, input int k, input int s, input int st,
                            input int dn, input int lat, input int iv);
    wait_count(k);
    check_output({name, "_valid"}, 64'(rec_valid), 64'd1);
    check_output(name, 64'({rec_seq, rec_start_ts, rec_done_ts, rec_latency, rec_interval}),
                 64'({16'(s), TS_W'(st), TS_W'(dn), TS_W'(lat), TS_W'(iv)}));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] single transaction");
    do_reset();
    apply_stimulus(5, 1, 0);
    apply_stimulus(12, 0, 1);
    expect_rec("single", 13, 0, 5, 12, 7, 0);
    wait_count(14);
    check_output("single_gone", 64'(rec_valid), 64'd0);

    $display("[TB] pipelined II=1");
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(10 + i, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(14 + i, 0, 1);
      expect_rec("pipe", 15 + i, i, 10 + i, 14 + i, 4, (i == 0) ? 0 : 1);
    end

    $display("[TB] combinational kernel");
    do_reset();
    apply_stimulus(20, 1, 1);
    expect_rec("comb", 21, 0, 20, 20, 0, 0);
    check_output("comb_err", 64'(err_flags), 64'd0);

    $display("[TB] backpressure");
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) apply_stimulus(2 + 2 * i, 1, 1);
    wait_count(25);
    check_output("bp_drop", 64'(drop_count), 64'd2);
    expect_rec("bp_stall_a", 25, 0, 2, 2, 0, 0);
    expect_rec("bp_stall_b", 28, 0, 2, 2, 0, 0);
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      expect_rec("bp_drain", 28 + i, i, 2 + 2 * i, 2 + 2 * i, 0, (i == 0) ? 0 : 2);
    wait_count(36);
    check_output("bp_empty", 64'(rec_valid), 64'd0);

    $display("[TB] error cases");
    do_reset();
    apply_stimulus(3, 0, 1);
    wait_count(4);
    check_output("spurious_err", 64'(err_flags), 64'd1);
    check_output("spurious_norec", 64'(rec_valid), 64'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(10 + i, 1, 0);
    wait_count(15);
    check_output("overflow_err", 64'(err_flags), 64'd3);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(20 + i, 0, 1);
      expect_rec("ovf_rec", 21 + i, i, 10 + i, 20 + i, 10, (i == 0) ? 0 : 1);
    end
    wait_count(25);
    check_output("ovf_no_seq4", 64'(rec_valid), 64'd0);

    $display("[TB] counter wrap");
    do_reset();
    apply_stimulus(250, 1, 0);
    apply_stimulus(4, 0, 1);
    expect_rec("wrap", 5, 0, 250, 4, 10, 0);

    $display("[TB] finish and drain");
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(2 + i, 1, 1);
    wait_count(10);
    finish = 1'b1;
    apply_stimulus(12, 1, 1);
    wait_count(15);
    rec_ready = 1'b1;
    expect_rec("fin_first", 15, 0, 2, 2, 0, 0);
    wait_count(17);
    check_output("fin_not_yet", 64'(flush_done), 64'd0);
    wait_count(18);
    check_output("fin_flushed", 64'(flush_done), 64'd1);
    check_output("fin_empty", 64'(rec_valid), 64'd0);
    apply_stimulus(20, 1, 1);
    wait_count(22);
    check_output("fin_ignored", 64'(rec_valid), 64'd0);
    check_output("fin_sticky", 64'(flush_done), 64'd1);
    do_reset();
    check_output("fin_cleared", 64'(flush_done), 64'd0);

    $display("[TB] reset mid-run");
    rec_ready = 1'b0;
    apply_stimulus(2, 0, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(3 + i, 1, 1);
    wait_count(8);
    check_output("mid_busy", 64'({rec_valid, err_flags}), 64'({1'b1, 2'b01}));
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check_output("mid_fields_zero",
                 64'({rec_seq, rec_start_ts, rec_done_ts, rec_latency, rec_interval}), 64'd0);
    check_output("mid_status_zero", 64'({rec_valid, drop_count, err_flags, flush_done}), 64'd0);
    ap_rst_n = 1'b1;

    $display("[TB] random traffic");
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      mon_start    = ($urandom_range(0, 99) < 55);
      mon_ready    = ($urandom_range(0, 99) < 70);
      mon_done     = ($urandom_range(0, 99) < 40);
      mon_continue = ($urandom_range(0, 99) < 90);
      rec_ready    = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 80));
      ap_rst_n     = (c != 1000);
      finish       = (c >= 2800);
      @(negedge ap_clk);
    end
    rec_ready = 1'b1;
    repeat (20) @(negedge ap_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ap_ctrl_txn_tracker.md
# ap_ctrl_txn_tracker

Synthesizable transaction tracker that sits directly upstream of the cosim dataflow/module-status dumper. It snoops the `ap_ctrl_hs` handshake (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`) of one non-dataflow HLS kernel and timestamps each transaction against a free-running cycle counter. It pairs starts with dones in order, computes latency and initiation interval, and buffers one record per transaction. Records leave on a valid/ready stream that the status dumper consumes and writes as CSV rows.

## Interface
- `TS_W`, 32: width of the cycle counter and of every timestamp, latency and interval field.
- `PEND_DEPTH`, 4: maximum number of outstanding started-but-not-done transactions. Power of 2, ≥2.
- `FIFO_DEPTH`, 8: depth of the output record FIFO. Power of 2, ≥2.

- `ap_clk`  in  1  clock. The only clock in the block.
- `ap_rst_n`  in  1  synchronous, active-low reset.
- `mon_start`  in  1  snooped `ap_start` of the kernel.
- `mon_ready`  in  1  snooped `ap_ready`.
- `mon_done`  in  1  snooped `ap_done`.
- `mon_continue`  in  1  snooped `ap_continue`. Tie to 1 for non-dataflow kernels.
- `finish`  in  1  end-of-simulation request, level.
- `rec_valid`  out  1  a record is presented on the output.
- `rec_ready`  in  1  the consumer accepts the record.
- `rec_seq`  out  16  transaction index, starting at 0 and wrapping.
- `rec_start_ts`  out  TS_W  cycle count at the start accept.
- `rec_done_ts`  out  TS_W  cycle count at done.
- `rec_latency`  out  TS_W  `done_ts - start_ts`, modulo 2^TS_W.
- `rec_interval`  out  TS_W  `start_ts` minus the previous start, modulo 2^TS_W. 0 for the first transaction.
- `drop_count`  out  16  records lost to a full FIFO. Saturates.
- `err_flags`  out  2  sticky error bits:
  - bit0: spurious done.
  - bit1: pending-queue overflow.
- `flush_done`  out  1  drain complete after `finish`. Sticky.

## Operation
- **Cycle counter**
  - Reset value 0.
  - +1 every cycle while `ap_rst_n`=1.
  - Wraps modulo 2^TS_W.
  - All events are stamped with the counter value in the cycle they are sampled.
- **Accept event:** `mon_start & mon_ready`.
  - Pushes `{seq, ts}` into the pending queue.
  - `interval = ts - last_accept_ts`. Forced to 0 on the first accept after reset.
  - Updates `last_accept_ts`.
  - `seq` increments by 1 per accept and wraps at 16 bits.
- **Done event:** `mon_done & mon_continue`.
  - Pops the oldest pending entry.
  - Forms a record with `done_ts` = current count and pushes it into the output FIFO.
- **Same-cycle accept and done:**
  - The accept is processed logically first.
  - If the pending queue was empty, the done pairs with that same-cycle start (latency 0).
  - If the pending queue was non-empty, the done pairs with the oldest entry, and the new start is enqueued.
- **Spurious done:** a done with the queue empty and no same-cycle accept.
  - Sets `err_flags[0]`.
  - No record is produced.
- **Pending overflow:** an accept while the queue is full and no same-cycle done.
  - The accept is ignored.
  - Sets `err_flags[1]`.
  - `seq` still increments, so the gap is visible downstream.
- **FIFO full on record push:** a simultaneous pop in the same cycle counts as space.
  - The record is discarded.
  - `drop_count` +1, saturating at 0xFFFF.
- **Finish:** once `finish`=1 is sampled, a sticky `finishing` bit is set.
  - New accepts and dones are ignored from that cycle onward.
  - `flush_done` rises when `finishing`=1, the FIFO is empty, and `rec_valid`=0.
- **Output state machine:** IDLE → FINISHING → FLUSHED.
  - Leaves IDLE only on `finish`.
  - FLUSHED is held until reset.

## Timing
- **Reset values:**
  - All outputs 0.
  - Counter 0, pending queue and FIFO empty, `last_accept_ts` 0, first-accept flag set.
- **Record latency:** a done event in cycle N with an empty FIFO gives `rec_valid`=1 in cycle N+1 (registered FIFO output).
- **Output handshake:**
  - A transfer occurs when `rec_valid & rec_ready`.
  - While `rec_valid & !rec_ready`, all `rec_*` fields are held stable.
  - `rec_valid` never drops without a transfer.
- **Throughput:** one record per cycle sustained (push and pop in the same cycle) when `rec_ready`=1.
- **Reset mid-operation:** a synchronous clear on the next edge.
  - In-flight records are discarded.
  - `drop_count` and `err_flags` are cleared.
  - `flush_done` returns to 0.
- **Wrap:** latency and interval are modular subtractions, so they stay correct across exactly one counter wrap.

## Test plan
- **Single transaction, `PEND_DEPTH`=4, `FIFO_DEPTH`=8.**
  - Stimulus: accept at count 5, done at count 12, `rec_ready`=1.
  - Required: one record {seq 0, start 5, done 12, latency 7, interval 0}, with `rec_valid` at count 13.
- **Pipelined kernel, II=1.**
  - Stimulus: accepts at counts 10, 11, 12; dones at 14, 15, 16.
  - Required: three records, each latency 4, with intervals 0, 1, 1.
- **Combinational kernel.**
  - Stimulus: accept and done in the same cycle at count 20.
  - Required: latency 0, no error flags.
- **Backpressure, `FIFO_DEPTH`=8.**
  - Stimulus: hold `rec_ready`=0 and complete 10 transactions.
  - Required: 8 records delivered in order once ready rises, `drop_count`=2, and held fields unchanged while stalled.
- **Error cases.**
  - Done with no accept: sets `err_flags[0]`, no record.
  - Five accepts with no done at `PEND_DEPTH`=4: sets `err_flags[1]`; the next record's seq is 0 and the fifth accept's seq (4) never appears.
- **Wrap, finish and reset, `TS_W`=8.**
  - Wrap: accept at count 250, done at count 4 → latency 10.
  - Finish: assert `finish` with 3 records queued; `flush_done` rises the cycle after the last transfer; later dones are ignored.
  - Reset: reset mid-run clears all state and outputs to 0.
